// File: rtl/rcs_div_ctrl_if.sv
// Request/result bundle for the restoring-division controller.
// The requester (master) drives start and the operands; the divider
// (slave) returns status and the held results.
interface rcs_div_ctrl_if;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/rcs_div_ctrl.sv
// Four-bit restoring divider controller.
// One ripple-carry adder/subtractor (four_bit_RCS, Sub tied high) is the only
// arithmetic unit; a three-state FSM walks it through four shift/subtract
// iterations and publishes quotient/remainder with a one-cycle done pulse.
// A zero divisor short-circuits straight to DONE with all-ones quotient.

// Ripple-carry adder/subtractor: S = A + (B ^ {4{Sub}}) + Sub.
// With Sub=1, Cout=1 means A >= B (no borrow).
module four_bit_RCS (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Sub,
    output logic [3:0] S,
    output logic       Cout
);
    logic [4:0] carry;
    logic [3:0] b_eff;

    // Bit-serial ripple through four full adders.
    always_comb begin
        carry    = '0;
        b_eff    = '0;
        S        = '0;
        carry[0] = Sub;
        for (int i = 0; i < 4; i++) begin
            b_eff[i]   = B[i] ^ Sub;
            S[i]       = A[i] ^ b_eff[i] ^ carry[i];
            carry[i+1] = (A[i] & b_eff[i]) | (A[i] & carry[i]) | (b_eff[i] & carry[i]);
        end
    end

    assign Cout = carry[4];
endmodule

module rcs_div_ctrl (
    input  logic               clk,
    input  logic               rst,
    rcs_div_ctrl_if.slave      bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] count;
    logic [3:0] q_reg;
    logic [3:0] r_reg;
    logic [3:0] d_reg;

    logic       busy_reg;
    logic       done_reg;
    logic [3:0] quot_reg;
    logic [3:0] rem_reg;
    logic       dbz_reg;

    // Iteration datapath: shift the next dividend bit into the partial
    // remainder, trial-subtract the divisor, and restore on borrow.
    logic [4:0] shifted;
    logic [3:0] rcs_s;
    logic       rcs_cout;
    logic       accepted;
    logic [3:0] r_next;
    logic [3:0] q_next;

    assign shifted = {r_reg, q_reg[3]};

    four_bit_RCS u_rcs (
        .A    (shifted[3:0]),
        .B    (d_reg),
        .Sub  (1'b1),
        .S    (rcs_s),
        .Cout (rcs_cout)
    );

    // A set shifted[4] means the 5-bit partial remainder already exceeds any
    // 4-bit divisor, so the subtraction always succeeds even though the
    // 4-bit subtractor reports a borrow.
    assign accepted = shifted[4] | rcs_cout;
    assign r_next   = accepted ? rcs_s : shifted[3:0];
    assign q_next   = {q_reg[2:0], accepted};

    // Controller FSM with registered status and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= 2'd0;
            q_reg    <= 4'd0;
            r_reg    <= 4'd0;
            d_reg    <= 4'd0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            quot_reg <= 4'd0;
            rem_reg  <= 4'd0;
            dbz_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        q_reg <= bus.dividend;
                        d_reg <= bus.divisor;
                        r_reg <= 4'd0;
                        if (bus.divisor != 4'd0) begin
                            state    <= RUN;
                            count    <= 2'd3;
                            busy_reg <= 1'b1;
                            done_reg <= 1'b0;
                        end else begin
                            // Division by zero: no iterations, report at once.
                            state    <= DONE;
                            count    <= 2'd0;
                            busy_reg <= 1'b0;
                            done_reg <= 1'b1;
                            quot_reg <= 4'b1111;
                            rem_reg  <= bus.dividend;
                            dbz_reg  <= 1'b1;
                        end
                    end else begin
                        state    <= IDLE;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b0;
                    end
                end

                RUN: begin
                    // start is deliberately not looked at here.
                    q_reg <= q_next;
                    r_reg <= r_next;
                    if (count == 2'd0) begin
                        state    <= DONE;
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                        quot_reg <= q_next;
                        rem_reg  <= r_next;
                        dbz_reg  <= 1'b0;
                    end else begin
                        count <= count - 2'd1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    count    <= 2'd0;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.quotient    = quot_reg;
    assign bus.remainder   = rem_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule
